// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter block: redirect sources and default vectors.
package pc_pkg;

  typedef enum logic [2:0] {
    SRC_NONE,
    SRC_SEQ,
    SRC_PEND,
    SRC_JUMP,
    SRC_RET,
    SRC_BR,
    SRC_EXC
  } redirect_src_e;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h8000_0180;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: push, pop, or replace-top, with the oldest entry
// overwritten when pushing onto a full stack.
module ras_stack #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 32,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_push_data,
  output logic [WIDTH-1:0] o_top,
  output logic [CW-1:0]    o_count,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_overflow
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;

  logic [PW-1:0]    w_top_idx;
  logic [PW-1:0]    w_wr_idx;
  logic             w_replace;

  assign w_top_idx = r_ptr - 1'b1;
  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign w_replace = i_push && i_pop && !o_empty;
  assign w_wr_idx  = w_replace ? w_top_idx : r_ptr;

  assign o_top      = r_mem[w_top_idx];
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

  // NOTE: storage array has no reset; r_count alone decides which entries are valid.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[w_wr_idx] <= i_push_data;
  end

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ptr      <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= i_push && !i_pop && o_full;
      if (i_push && !w_replace) begin
        // Plain push (or replace on empty, which behaves as a push); on full the pointer lands on the oldest slot.
        r_ptr <= r_ptr + 1'b1;
        if (!o_full) r_count <= r_count + 1'b1;
      end else if (i_pop && !i_push && !o_empty) begin
        r_ptr   <= w_top_idx;
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_control_unit.sv
// IF-stage program counter: prioritised next-PC selection, one-entry pending redirect
// held across stalls, and call/return prediction through a return-address stack.
module pc_control_unit
  import pc_pkg::*;
#(
  parameter  int               WIDTH        = 32,
  parameter  logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
  parameter  logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEF_EXC_VECTOR),
  parameter  int               INC          = 4,
  parameter  int               RAS_DEPTH    = 4,
  localparam int               CW           = $clog2(RAS_DEPTH + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             PCWrite,
  input  logic             ExcValid,
  input  logic             BranchTaken,
  input  logic [WIDTH-1:0] BranchTarget,
  input  logic             JumpValid,
  input  logic [WIDTH-1:0] JumpTarget,
  input  logic             Call,
  input  logic             Return,
  output logic [WIDTH-1:0] PCResult,
  output logic [WIDTH-1:0] PCPlusInc,
  output logic [CW-1:0]    RasCount,
  output logic             RasEmpty,
  output logic             RasFull,
  output logic             RasOverflow
);

  logic [WIDTH-1:0] r_pc;
  logic             r_pend_valid;
  logic [WIDTH-1:0] r_pend_target;

  redirect_src_e    w_src;
  logic [WIDTH-1:0] w_target;
  logic [WIDTH-1:0] w_ras_top;
  logic             w_jump_wins;
  logic             w_ras_push;
  logic             w_ras_pop;

  assign PCResult  = r_pc;
  assign PCPlusInc = r_pc + WIDTH'(INC);

  // RAS only moves when the jump itself is the winning redirect.
  assign w_jump_wins = JumpValid && !ExcValid && !BranchTaken;
  assign w_ras_push  = w_jump_wins && Call;
  assign w_ras_pop   = w_jump_wins && Return;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_src    = SRC_NONE;
    w_target = r_pc;
    if (ExcValid) begin
      w_src    = SRC_EXC;
      w_target = EXC_VECTOR;
    end else if (BranchTaken) begin
      w_src    = SRC_BR;
      w_target = BranchTarget;
    end else if (JumpValid && Return) begin
      w_src    = SRC_RET;
      w_target = RasEmpty ? JumpTarget : w_ras_top;
    end else if (JumpValid) begin
      w_src    = SRC_JUMP;
      w_target = JumpTarget;
    end else if (PCWrite && r_pend_valid) begin
      w_src    = SRC_PEND;
      w_target = r_pend_target;
    end else if (PCWrite) begin
      w_src    = SRC_SEQ;
      w_target = PCPlusInc;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_pc          <= RESET_VECTOR;
      r_pend_valid  <= 1'b0;
      r_pend_target <= '0;
    end else begin
      case (w_src)
        SRC_EXC, SRC_PEND, SRC_SEQ: begin
          r_pc         <= w_target;
          r_pend_valid <= 1'b0;
        end
        SRC_BR, SRC_RET, SRC_JUMP: begin
          if (PCWrite) begin
            r_pc         <= w_target;
            r_pend_valid <= 1'b0;
          end else begin
            r_pend_valid  <= 1'b1;
            r_pend_target <= w_target;
          end
        end
        default: ;
      endcase
    end
  end

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (WIDTH)
  ) u_ras (
    .i_clk       (Clk),
    .i_reset     (Reset),
    .i_push      (w_ras_push),
    .i_pop       (w_ras_pop),
    .i_push_data (PCPlusInc),
    .o_top       (w_ras_top),
    .o_count     (RasCount),
    .o_empty     (RasEmpty),
    .o_full      (RasFull),
    .o_overflow  (RasOverflow)
  );

endmodule
